mult16_seq_ctrl: RTL
====================

// Module: mult16_seq_ctrl
// PURPOSE
//  Sequencer that computes a signed 16x16 -> 32-bit product on ONE shared, external unsigned mult8x8 (approx) unit.
//  Operands are converted to magnitudes, then four 8x8 partial products are scheduled over successive cycles.
//  The partial products are accumulated and the sign is re-applied.
//  Sits in approx_mac/cmac as the area-reduced alternative to four parallel mult8x8 instances; valid/ready on both sides.
// PARAMETERS
//  ZERO_SKIP  1  1: skip partial-product phases whose a-byte or b-byte is 0; 0: always run all 4 phases
// PORTS
//  nvdla_core_clk  in   1   core clock; all state on rising edge
//  nvdla_core_rst  in   1   reset, asynchronous, active-high
//  in_valid        in   1   operand pair valid
//  in_ready        out  1   block can accept operands this cycle
//  in_a            in   16  two's-complement operand A
//  in_b            in   16  two's-complement operand B
//  mul_en          out  1   shared mult8x8 in use this cycle (gating/arbitration)
//  mul_a           out  8   mult8x8 operand a (unsigned byte)
//  mul_b           out  8   mult8x8 operand b (unsigned byte)
//  mul_p           in   16  mult8x8 product, combinational from mul_a/mul_b, same cycle
//  out_valid       out  1   result valid; held until accepted
//  out_ready       in   1   consumer accepts result
//  out_data        out  32  formatted signed result
//  busy            out  1   state != IDLE
// BEHAVIOUR
//  Reset (async, any state, including mid-phase):
//   - state=IDLE; acc, out_data, phase = 0.
//   - out_valid, mul_en, busy = 0; mul_a = mul_b = 0; in_ready = 1 after reset deasserts.
//  Operand capture (accept edge = in_valid & in_ready):
//   - magA = a[15] ? -a : a, as unsigned 16-bit (0x8000 stays 0x8000); same rule for magB.
//   - sgn = a[15]^b[15]; acc = 0.
//  Phases, in order; each contributes mul_p shifted left by the weight into a 32-bit acc:
//   - P0: aL*bL, weight 0
//   - P1: aH*bL, weight 8
//   - P2: aL*bH, weight 8
//   - P3: aH*bH, weight 16
//  ZERO_SKIP=1: phase k is scheduled only if both of its bytes are nonzero; its contribution is 0 otherwise.
//  FSM IDLE -> MUL -> DONE:
//   - IDLE: in_ready=1. On accept -> MUL at the first scheduled phase. If no phase is scheduled
//     (ZERO_SKIP=1 and a or b is zero), go straight to DONE with out_data = fmt(0), loaded on the accept edge.
//   - MUL: mul_en=1; mul_a/mul_b = bytes of the current phase (combinational from phase reg).
//     Each edge: acc += mul_p<<w, advance to the next scheduled phase.
//     On the last scheduled phase's edge: out_data <= fmt(acc + (mul_p<<w)), out_valid<=1, -> DONE. in_ready=0.
//   - DONE: out_valid=1; out_data stable while out_ready=0.
//     in_ready = out_ready (same-cycle handoff).
//     out_ready&~in_valid -> IDLE, out_valid=0.
//     out_ready&in_valid -> capture the new operands; next state follows the IDLE accept rules.
//  fmt(m) = {sgn, t[30:0]}, where t = sgn ? (~m+1) : m (32-bit wrap).
//   - Magnitude is at most 2^30, so no overflow.
//   - Required corner: zero magnitude with sgn=1 gives 0x80000000 (not 0). Consumers depend on this encoding.
//  Latency, accept edge to out_valid high: N edges, N = number of scheduled phases (4 when ZERO_SKIP=0; 0..4 otherwise).
//   - N=0: out_valid is high the cycle after accept.
//  Throughput: one result per N+1 cycles under continuous in_valid/out_ready (N=0 case: one per cycle).
//  mul_en=0, mul_a=mul_b=0 outside MUL; the shared unit is never driven while idle.
//  in_valid while busy is ignored; the producer must hold its operands until in_ready.
// TESTING
//  T1 ZERO_SKIP=0, a=0x0003, b=0x0005 -> mul_en high exactly 4 cycles; out_data=0x0000000F, sgn 0.
//  T2 a=0xFFFE(-2), b=0x0003 -> single phase P0 (ZERO_SKIP=1); out_data=0xFFFFFFFA one edge after accept+1.
//  T3 a=0x8000, b=0x8000 -> only P3 runs, mul_a=mul_b=0x80; out_data=0x40000000.
//  T4 a=0x0000, b=0xFFFB -> mul_en never rises; out_valid next cycle; out_data=0x80000000.
//  T5 a=0x1234, b=0x5678 (ZERO_SKIP=0); hold out_ready=0 for 3 cycles.
//     -> out_data stable at 0x06260060 and in_ready=0.
//     Then out_ready=1 with in_valid=1 -> new operands accepted that same cycle.
//  T6 assert nvdla_core_rst during MUL phase 2 -> all outputs 0 immediately.
//     After release: in_ready=1, and the next transaction (a=-1, b=-1) gives 0x00000001.

Source files
------------

// File: rtl/mult16_seq_ctrl.sv
// rtl/mult16_seq_ctrl.sv - signed 16x16 multiply sequenced over one shared 8x8 unit
//
// Purpose: accepts two signed 16-bit operands and converts them to magnitudes.
// It schedules up to four 8x8 partial products on an external combinational
// unsigned multiplier and accumulates them. It then re-applies the sign as
// {sgn, t[30:0]}, so a zero magnitude with a negative sign reads 0x80000000.
//
// Ports:
//   nvdla_core_clk  clock, rising edge
//   nvdla_core_rst  asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b      operand handshake and two's-complement operands
//   mul_en/mul_a/mul_b/mul_p         shared 8x8 multiplier port (mul_p same cycle)
//   out_valid/out_ready/out_data     result handshake and formatted signed result
//   busy            high whenever the sequencer is not idle
module mult16_seq_ctrl #(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        mul_en,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] mag_a, mag_b;
  logic        sgn;
  logic [3:0]  sched;
  logic [1:0]  phase;
  logic [31:0] acc;
  logic [31:0] out_data_r;

  logic [15:0] in_mag_a, in_mag_b;
  logic [3:0]  in_sched;
  logic        in_sgn;
  logic        can_take, accept;
  logic [3:0]  later;
  logic        last;
  logic [31:0] sh_p, acc_sum;

  // Bit k set means phase k needs the multiplier: P0 aL*bL, P1 aH*bL, P2 aL*bH, P3 aH*bH.
  function automatic logic [3:0] sched_of(input logic [15:0] ma, input logic [15:0] mb);
    logic al, ah, bl, bh;
    al = |ma[7:0];
    ah = |ma[15:8];
    bl = |mb[7:0];
    bh = |mb[15:8];
    if (ZERO_SKIP == 1'b0) return 4'hF;
    return {ah & bh, al & bh, ah & bl, al & bl};
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  // Sign is carried in bit 31 even for a zero magnitude; downstream relies on it.
  function automatic logic [31:0] fmt(input logic [31:0] m, input logic s);
    logic [31:0] t;
    t = s ? (~m + 32'd1) : m;
    return {s, t[30:0]};
  endfunction

  // 0x8000 negates to itself, which is the correct unsigned magnitude.
  assign in_mag_a = in_a[15] ? (~in_a + 16'd1) : in_a;
  assign in_mag_b = in_b[15] ? (~in_b + 16'd1) : in_b;
  assign in_sgn   = in_a[15] ^ in_b[15];
  assign in_sched = sched_of(in_mag_a, in_mag_b);

  assign can_take = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && can_take;
  assign in_ready = can_take && !nvdla_core_rst;

  // Phases still pending after the current one; none left means this is the final edge.
  assign later = sched & (4'hF << ({1'b0, phase} + 3'd1));
  assign last  = (later == 4'h0);

  always_comb begin
    sh_p = 32'h0;
    case (phase)
      2'd0:    sh_p = {16'h0, mul_p};
      2'd1:    sh_p = {8'h0, mul_p, 8'h0};
      2'd2:    sh_p = {8'h0, mul_p, 8'h0};
      default: sh_p = {mul_p, 16'h0};
    endcase
  end

  assign acc_sum = acc + sh_p;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_en    = 1'b0;
    mul_a     = 8'h00;
    mul_b     = 8'h00;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (in_sched == 4'h0) ? DONE : MUL;
      end
      MUL: begin
        mul_en = 1'b1;
        case (phase)
          2'd0: begin mul_a = mag_a[7:0];  mul_b = mag_b[7:0];  end
          2'd1: begin mul_a = mag_a[15:8]; mul_b = mag_b[7:0];  end
          2'd2: begin mul_a = mag_a[7:0];  mul_b = mag_b[15:8]; end
          default: begin mul_a = mag_a[15:8]; mul_b = mag_b[15:8]; end
        endcase
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) state_nxt = (in_sched == 4'h0) ? DONE : MUL;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      mag_a      <= 16'h0;
      mag_b      <= 16'h0;
      sgn        <= 1'b0;
      sched      <= 4'h0;
      phase      <= 2'd0;
      acc        <= 32'h0;
      out_data_r <= 32'h0;
    end else if (accept) begin
      mag_a <= in_mag_a;
      mag_b <= in_mag_b;
      sgn   <= in_sgn;
      sched <= in_sched;
      acc   <= 32'h0;
      phase <= lowest(in_sched);
      if (in_sched == 4'h0) out_data_r <= fmt(32'h0, in_sgn);
    end else if (state == MUL) begin
      acc <= acc_sum;
      if (last) out_data_r <= fmt(acc_sum, sgn);
      else      phase      <= lowest(later);
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
